// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: Tuse/Tnew register hazards,
// mult/div busy sequencing and a saturating stall-cycle counter.
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic             d_is_md,
  input  logic [4:0]       e_wa,
  input  logic [1:0]       e_tnew,
  input  logic             e_md_start,
  input  logic             e_md_div,
  input  logic [4:0]       m_wa,
  input  logic [1:0]       m_tnew,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_clr,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MD_W   = $clog2(MD_MAX + 1);
  localparam logic [MD_W-1:0] MULT_LOAD = MD_W'(MULT_CYCLES);
  localparam logic [MD_W-1:0] DIV_LOAD  = MD_W'(DIV_CYCLES);

  logic [MD_W-1:0] md_cnt;
  logic [MD_W-1:0] md_cnt_next;
  logic            md_done_next;

  // Source operand 0 is rs, operand 1 is rt.
  logic [4:0] src_reg  [2];
  logic       src_use  [2];
  logic [1:0] src_tuse [2];
  logic [1:0] hz_e;
  logic [1:0] hz_m;
  logic       hz_md;
  logic       stall;

  assign src_reg[0]  = d_rs;
  assign src_reg[1]  = d_rt;
  assign src_use[0]  = d_use_rs;
  assign src_use[1]  = d_use_rt;
  assign src_tuse[0] = d_tuse_rs;
  assign src_tuse[1] = d_tuse_rt;

  // A hazard exists only when the operand is needed before the producer can forward it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign hz_e[gi] = src_use[gi] & (src_reg[gi] != 5'd0) &
                        (src_reg[gi] == e_wa) & (src_tuse[gi] < e_tnew);
      assign hz_m[gi] = src_use[gi] & (src_reg[gi] != 5'd0) &
                        (src_reg[gi] == m_wa) & (src_tuse[gi] < m_tnew);
    end
  endgenerate

  assign hz_md = d_is_md & (md_busy | e_md_start);
  assign stall = (|hz_e) | (|hz_m) | hz_md;

  assign pc_en    = rst | ~stall;
  assign ifid_en  = rst | ~stall;
  assign idex_clr = ~rst & stall;

  // A new start always reloads, so an overwritten operation never produces md_done.
  always_comb begin
    md_cnt_next  = md_cnt;
    md_done_next = 1'b0;
    if (e_md_start) begin
      md_cnt_next = e_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt_next  = md_cnt - 1'b1;
      md_done_next = (md_cnt == MD_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt    <= '0;
      md_busy   <= 1'b0;
      md_done   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      md_cnt  <= md_cnt_next;
      md_busy <= (md_cnt_next != '0);
      md_done <= md_done_next;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares one per cycle.
module tb_stall_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    d_rs, d_rt, e_wa, m_wa;
  logic          d_use_rs, d_use_rt, d_is_md, e_md_start, e_md_div;
  logic [1:0]    d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic          pc_en, ifid_en, idex_clr, md_busy, md_done;
  logic [CW-1:0] stall_cnt;

  typedef struct {
    string         name;
    logic          pc_en;
    logic          ifid_en;
    logic          idex_clr;
    logic          md_busy;
    logic          md_done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt  = '0;

  stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .e_wa(e_wa), .e_tnew(e_tnew), .e_md_start(e_md_start), .e_md_div(e_md_div),
    .m_wa(m_wa), .m_tnew(m_tnew),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_clr(idex_clr),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic clr();
    d_rs = 5'd0; d_rt = 5'd0; d_use_rs = 1'b0; d_use_rt = 1'b0;
    d_tuse_rs = 2'd0; d_tuse_rt = 2'd0; d_is_md = 1'b0;
    e_wa = 5'd0; e_tnew = 2'd0; e_md_start = 1'b0; e_md_div = 1'b0;
    m_wa = 5'd0; m_tnew = 2'd0;
  endtask

  task automatic load_use();
    clr();
    e_wa = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_use_rs = 1'b1; d_tuse_rs = 2'd1;
  endtask

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic check(input string name, input logic stall, input logic busy,
                       input logic done, input logic in_rst);
    exp_t e;
    e.name     = name;
    e.pc_en    = in_rst ? 1'b1 : ~stall;
    e.ifid_en  = in_rst ? 1'b1 : ~stall;
    e.idex_clr = in_rst ? 1'b0 : stall;
    e.md_busy  = busy;
    e.md_done  = done;
    e.cnt      = exp_cnt;
    sb.push_back(e);
    if (stall && !in_rst && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (pc_en !== e.pc_en || ifid_en !== e.ifid_en || idex_clr !== e.idex_clr ||
          md_busy !== e.md_busy || md_done !== e.md_done || stall_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s: got pc_en=%b ifid_en=%b idex_clr=%b md_busy=%b md_done=%b stall_cnt=%0d, expected pc_en=%b ifid_en=%b idex_clr=%b md_busy=%b md_done=%b stall_cnt=%0d",
                 e.name, pc_en, ifid_en, idex_clr, md_busy, md_done, stall_cnt,
                 e.pc_en, e.ifid_en, e.idex_clr, e.md_busy, e.md_done, e.cnt);
      end else begin
        $display("ok   %s: pc_en=%b idex_clr=%b md_busy=%b md_done=%b stall_cnt=%0d",
                 e.name, pc_en, idex_clr, md_busy, md_done, stall_cnt);
      end
    end
  end

  initial begin
    clr();
    @(posedge clk); #1;
    load_use();
    check("reset_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // Register-file hazards
    load_use();
    check("load_use", 1'b1, 1'b0, 1'b0, 1'b0);
    clr(); e_wa = 5'd0; d_rs = 5'd0; d_use_rs = 1'b1; e_tnew = 2'd2; d_tuse_rs = 2'd0;
    check("zero_reg", 1'b0, 1'b0, 1'b0, 1'b0);
    clr(); d_rt = 5'd5; d_use_rt = 1'b1; d_tuse_rt = 2'd0; m_wa = 5'd5; m_tnew = 2'd1;
    check("m_hazard_rt", 1'b1, 1'b0, 1'b0, 1'b0);
    d_tuse_rt = 2'd1;
    check("m_no_hazard_rt", 1'b0, 1'b0, 1'b0, 1'b0);
    clr(); e_wa = 5'd3; e_tnew = 2'd1; d_rs = 5'd3; d_use_rs = 1'b1; d_tuse_rs = 2'd1;
    check("tuse_eq_tnew", 1'b0, 1'b0, 1'b0, 1'b0);
    clr(); d_rt = 5'd9; e_wa = 5'd9; e_tnew = 2'd3; d_use_rt = 1'b0;
    check("rt_unused", 1'b0, 1'b0, 1'b0, 1'b0);
    d_use_rt = 1'b1;
    check("e_hazard_rt", 1'b1, 1'b0, 1'b0, 1'b0);

    // Multiply with an md instruction waiting in ID
    clr(); e_md_start = 1'b1; d_is_md = 1'b1;
    check("mult_issue", 1'b1, 1'b0, 1'b0, 1'b0);
    e_md_start = 1'b0;
    for (int i = 0; i < 5; i++) check("mult_busy", 1'b1, 1'b1, 1'b0, 1'b0);
    check("mult_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("mult_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Divide overwritten by a multiply three edges later
    clr(); e_md_start = 1'b1; e_md_div = 1'b1;
    check("div_issue", 1'b0, 1'b0, 1'b0, 1'b0);
    clr();
    for (int i = 0; i < 2; i++) check("div_busy", 1'b0, 1'b1, 1'b0, 1'b0);
    e_md_start = 1'b1;
    check("restart_issue", 1'b0, 1'b1, 1'b0, 1'b0);
    clr();
    for (int i = 0; i < 5; i++) check("restart_busy", 1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reload on the same edge the count reaches zero
    e_md_start = 1'b1;
    check("mult2_issue", 1'b0, 1'b0, 1'b0, 1'b0);
    clr();
    for (int i = 0; i < 4; i++) check("mult2_busy", 1'b0, 1'b1, 1'b0, 1'b0);
    e_md_start = 1'b1;
    check("reload_at_end", 1'b0, 1'b1, 1'b0, 1'b0);
    clr();
    for (int i = 0; i < 5; i++) check("reload_busy", 1'b0, 1'b1, 1'b0, 1'b0);
    check("reload_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("reload_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a divide (count = 6)
    e_md_start = 1'b1; e_md_div = 1'b1;
    check("div2_issue", 1'b0, 1'b0, 1'b0, 1'b0);
    clr();
    for (int i = 0; i < 4; i++) check("div2_busy", 1'b0, 1'b1, 1'b0, 1'b0);
    load_use();
    rst = 1'b1;
    exp_cnt = '0;
    check("async_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    clr();
    for (int i = 0; i < 10; i++) check("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall counter saturation
    load_use();
    for (int i = 0; i < 18; i++) check("sat_stall", 1'b1, 1'b0, 1'b0, 1'b0);
    clr();
    check("sat_hold", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
